// File: rtl/pzcorebus_ordered_response_mux.sv
// Ordered response mux: a select FIFO records which slave owns each outstanding packet and
// steers that slave's response beats to the master port. Optional output skid buffer via
// PZCOREBUS_ORDERED_RESPONSE_MUX_OUTPUT_SLICE_EN.
module pzcorebus_ordered_response_mux #(
    parameter int SLAVES         = 2,
    parameter int RESPONSE_WIDTH = 64,
    parameter int DEPTH          = 4,
    parameter int SELECT_WIDTH   = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic                                     i_select_valid,
    output logic                                     o_select_ready,
    input  logic [SELECT_WIDTH-1:0]                  i_select,
    output logic                                     o_select_error,
    output logic [$clog2(DEPTH+1)-1:0]               o_outstanding,
    input  logic [SLAVES-1:0]                        i_slave_sresp_valid,
    output logic [SLAVES-1:0]                        o_slave_mresp_accept,
    input  logic [SLAVES-1:0][RESPONSE_WIDTH-1:0]    i_slave_sresp,
    input  logic [SLAVES-1:0]                        i_slave_sresp_last,
    output logic                                     o_master_sresp_valid,
    input  logic                                     i_master_mresp_accept,
    output logic [RESPONSE_WIDTH-1:0]                o_master_sresp,
    output logic                                     o_master_sresp_last
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [SELECT_WIDTH:0]  SLAVE_COUNT = (SELECT_WIDTH + 1)'(SLAVES);
    localparam logic [PTR_WIDTH-1:0]   PTR_LAST    = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_FULL    = CNT_WIDTH'(DEPTH);

    logic [SELECT_WIDTH-1:0]   fifo_r [DEPTH];
    logic [PTR_WIDTH-1:0]      wr_ptr_r;
    logic [PTR_WIDTH-1:0]      rd_ptr_r;
    logic [CNT_WIDTH-1:0]      count_r;
    logic                      error_r;

    logic                      full_s;
    logic                      empty_s;
    logic                      in_range_s;
    logic                      push_s;
    logic                      pop_s;
    logic [SELECT_WIDTH-1:0]   head_s;
    logic                      merged_valid_s;
    logic                      merged_last_s;
    logic                      merged_accept_s;
    logic [RESPONSE_WIDTH-1:0] merged_data_s;
    logic [SLAVES-1:0]         slave_accept_s;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PTR_WIDTH{1'b0}};
        end else begin
            return ptr + PTR_WIDTH'(1);
        end
    endfunction

    // Select FIFO status and push qualification
    always_comb begin
        full_s     = (count_r == CNT_FULL);
        empty_s    = (count_r == {CNT_WIDTH{1'b0}});
        in_range_s = ({1'b0, i_select} < SLAVE_COUNT);
        push_s     = i_select_valid && !full_s && in_range_s;
        head_s     = fifo_r[rd_ptr_r];
    end

    // Steer the head slave onto the merged path; everyone else is held off
    always_comb begin
        merged_valid_s = 1'b0;
        merged_last_s  = 1'b0;
        merged_data_s  = {RESPONSE_WIDTH{1'b0}};
        slave_accept_s = {SLAVES{1'b0}};
        if (!empty_s) begin
            merged_valid_s         = i_slave_sresp_valid[head_s];
            merged_last_s          = i_slave_sresp_last[head_s];
            merged_data_s          = i_slave_sresp[head_s];
            slave_accept_s[head_s] = merged_accept_s;
        end else begin
            slave_accept_s = {SLAVES{1'b0}};
        end
        pop_s = merged_valid_s && merged_accept_s && merged_last_s;
    end

    // Select FIFO storage, pointers, occupancy and error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {SELECT_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
            error_r  <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= i_select;
                wr_ptr_r         <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
            error_r <= i_select_valid && !full_s && !in_range_s;
        end
    end

    assign o_select_ready       = !full_s;
    assign o_select_error       = error_r;
    assign o_outstanding        = count_r;
    assign o_slave_mresp_accept = slave_accept_s;

`ifdef PZCOREBUS_ORDERED_RESPONSE_MUX_OUTPUT_SLICE_EN
    logic                      out_valid_r;
    logic                      out_last_r;
    logic [RESPONSE_WIDTH-1:0] out_data_r;
    logic                      skid_valid_r;
    logic                      skid_last_r;
    logic [RESPONSE_WIDTH-1:0] skid_data_r;
    logic                      in_fire_s;
    logic                      out_free_s;

    // Upstream is accepted whenever the skid slot is free
    always_comb begin
        merged_accept_s = !skid_valid_r;
        in_fire_s       = merged_valid_s && !skid_valid_r;
        out_free_s      = !out_valid_r || i_master_mresp_accept;
    end

    // Output register refills from the skid slot first to keep beat order
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {RESPONSE_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_data_r  <= {RESPONSE_WIDTH{1'b0}};
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_last_r   <= skid_last_r;
                out_data_r   <= skid_data_r;
                skid_valid_r <= 1'b0;
            end else if (in_fire_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= merged_last_s;
                out_data_r  <= merged_data_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_valid_r <= 1'b1;
            skid_last_r  <= merged_last_s;
            skid_data_r  <= merged_data_s;
        end
    end

    assign o_master_sresp_valid = out_valid_r;
    assign o_master_sresp_last  = out_last_r;
    assign o_master_sresp       = out_data_r;
`else
    // Zero-latency path: downstream accept feeds straight back to the head slave
    always_comb begin
        merged_accept_s = i_master_mresp_accept;
    end

    assign o_master_sresp_valid = merged_valid_s;
    assign o_master_sresp_last  = merged_last_s;
    assign o_master_sresp       = merged_data_s;
`endif

endmodule

// File: tb/tb_pzcorebus_ordered_response_mux.sv
// Scoreboard bench for pzcorebus_ordered_response_mux (SLAVES=3, DEPTH=4, 16-bit payload).
module tb_pzcorebus_ordered_response_mux;
    localparam int SLAVES = 3;
    localparam int RW     = 16;
    localparam int DEPTH  = 4;
    localparam int SW     = 2;
    localparam int OW     = 3;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          last;
    } beat_t;

    logic                       clk;
    logic                       rst_n;
    logic                       sel_valid;
    logic                       sel_ready;
    logic [SW-1:0]              sel;
    logic                       sel_error;
    logic [OW-1:0]              outstanding;
    logic [SLAVES-1:0]          s_valid;
    logic [SLAVES-1:0]          s_accept;
    logic [SLAVES-1:0][RW-1:0]  s_data;
    logic [SLAVES-1:0]          s_last;
    logic                       m_valid;
    logic                       m_accept;
    logic [RW-1:0]              m_data;
    logic                       m_last;

    beat_t         exp_q[$];
    beat_t         mon_b;
    logic          hold_q;
    logic [RW-1:0] held_data;
    int            checks;
    int            errors;
    logic          pkt_done;

    pzcorebus_ordered_response_mux #(
        .SLAVES(SLAVES), .RESPONSE_WIDTH(RW), .DEPTH(DEPTH), .SELECT_WIDTH(SW)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_select_valid       (sel_valid),
        .o_select_ready       (sel_ready),
        .i_select             (sel),
        .o_select_error       (sel_error),
        .o_outstanding        (outstanding),
        .i_slave_sresp_valid  (s_valid),
        .o_slave_mresp_accept (s_accept),
        .i_slave_sresp        (s_data),
        .i_slave_sresp_last   (s_last),
        .o_master_sresp_valid (m_valid),
        .i_master_mresp_accept(m_accept),
        .o_master_sresp       (m_data),
        .o_master_sresp_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor plus hold-stability check on the master port
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, expected valid=1 data=%h", m_valid, m_data, held_data);
                end
            end
            hold_q    = m_valid && !m_accept;
            held_data = m_data;
            if (m_valid && m_accept) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h last=%b, expected no beat", m_data, m_last);
                end else begin
                    mon_b = exp_q.pop_front();
                    if ({m_data, m_last} !== {mon_b.data, mon_b.last}) begin
                        errors++;
                        $display("FAIL beat_order: got data=%h last=%b, expected data=%h last=%b", m_data, m_last, mon_b.data, mon_b.last);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] idx);
        sel_valid = 1'b1;
        sel       = idx;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic drive_beat(input int s, input logic [RW-1:0] d, input logic l);
        beat_t b;
        bit    done;
        done      = 1'b0;
        s_valid[s] = 1'b1;
        s_data[s]  = d;
        s_last[s]  = l;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (s_accept[s]) done = 1'b1;
        end
        step();
        s_valid[s] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL beat_accept: slave %0d data=%h accepted=%0b, expected 1", s, d, done);
        end
    endtask

    task automatic wait_drain();
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 50 && !drained; i++) begin
            @(negedge clk);
            drained = (exp_q.size() == 0) && (outstanding == 3'd0);
        end
        step();
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL drain: pending beats=%0d outstanding=%0d, expected 0 and 0", exp_q.size(), outstanding);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d, expected 0", outstanding); end
        if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", sel_ready); end
        if (sel_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, expected 0", sel_error); end
        if (s_accept !== 3'b000) begin errors++; $display("FAIL reset_accept: got %b, expected 000", s_accept); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", m_valid); end
        step();
        rst_n   = 1'b1;
        s_valid = 3'b000;
        step();
    endtask

    task automatic test_order();
        push(2'd1); push(2'd0); push(2'd1);
        checks++;
        if (outstanding !== 3'd3) begin errors++; $display("FAIL order_outstanding: got %0d, expected 3", outstanding); end
        s_valid[0] = 1'b1; s_data[0] = 16'hA000; s_last[0] = 1'b1;
        drive_beat(1, 16'h1100, 1'b0);
        @(negedge clk);
        checks++;
        if (s_accept[0] !== 1'b0) begin errors++; $display("FAIL early_accept: got %b, expected 0", s_accept[0]); end
        step();
        drive_beat(1, 16'h1101, 1'b1);
        checks++;
        if (outstanding !== 3'd2) begin errors++; $display("FAIL order_pop: got %0d, expected 2", outstanding); end
        exp_q.push_back('{data: 16'hA000, last: 1'b1});
        @(negedge clk);
        checks++;
        if (s_accept[0] !== 1'b1) begin errors++; $display("FAIL late_accept: got %b, expected 1", s_accept[0]); end
        step();
        s_valid[0] = 1'b0;
        drive_beat(1, 16'h1200, 1'b1);
        wait_drain();
    endtask

    task automatic test_full();
        push(2'd0); push(2'd1); push(2'd2); push(2'd0);
        checks += 2;
        if (outstanding !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, expected 4", outstanding); end
        if (sel_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", sel_ready); end
        sel_valid = 1'b1; sel = 2'd1;
        step();
        checks++;
        if (outstanding !== 3'd4) begin errors++; $display("FAIL full_held: got %0d, expected 4", outstanding); end
        drive_beat(0, 16'h2000, 1'b1);
        checks++;
        if (outstanding !== 3'd3) begin errors++; $display("FAIL full_pop_push: got %0d, expected 3", outstanding); end
        step();
        sel_valid = 1'b0;
        checks++;
        if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d, expected 4", outstanding); end
        drive_beat(1, 16'h2101, 1'b1);
        sel_valid = 1'b1; sel = 2'd2;
        drive_beat(2, 16'h2202, 1'b1);
        sel_valid = 1'b0;
        checks++;
        if (outstanding !== 3'd3) begin errors++; $display("FAIL simul_push_pop: got %0d, expected 3", outstanding); end
        drive_beat(0, 16'h2300, 1'b1);
        drive_beat(1, 16'h2401, 1'b1);
        drive_beat(2, 16'h2502, 1'b1);
        wait_drain();
    endtask

    task automatic test_error();
        push(2'd0);
        sel_valid = 1'b1; sel = 2'd3;
        @(negedge clk);
        checks++;
        if (sel_error !== 1'b0) begin errors++; $display("FAIL error_early: got %b, expected 0", sel_error); end
        step();
        sel_valid = 1'b0;
        checks += 2;
        if (sel_error !== 1'b1) begin errors++; $display("FAIL error_pulse: got %b, expected 1", sel_error); end
        if (outstanding !== 3'd1) begin errors++; $display("FAIL error_no_enqueue: got %0d, expected 1", outstanding); end
        step();
        checks++;
        if (sel_error !== 1'b0) begin errors++; $display("FAIL error_one_cycle: got %b, expected 0", sel_error); end
`ifndef PZCOREBUS_ORDERED_RESPONSE_MUX_OUTPUT_SLICE_EN
        m_accept = 1'b0;
        s_valid[0] = 1'b1; s_data[0] = 16'h3000; s_last[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h3000) begin
            errors++;
            $display("FAIL zero_latency: valid=%b data=%h, expected valid=1 data=3000", m_valid, m_data);
        end
        step();
        m_accept = 1'b1;
`endif
        drive_beat(0, 16'h3000, 1'b1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        push(2'd2);
        pkt_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    drive_beat(2, 16'h4000 + 16'(b), (b == 3) ? 1'b1 : 1'b0);
                    if (b == 2) begin
                        checks++;
                        if (outstanding !== 3'd1) begin errors++; $display("FAIL bp_no_early_pop: got %0d, expected 1", outstanding); end
                    end
                end
                pkt_done = 1'b1;
            end
            begin
                while (!pkt_done) begin
                    step();
                    m_accept = ~m_accept;
                end
            end
        join
        m_accept = 1'b1;
        checks++;
        if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_single_pop: got %0d, expected 0", outstanding); end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        push(2'd2); push(2'd0); push(2'd1);
        drive_beat(2, 16'h5000, 1'b0);
        drive_beat(2, 16'h5001, 1'b0);
        s_valid = 3'b111; s_data[2] = 16'h5002; s_last = 3'b001;
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        checks += 3;
        if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_mid_outstanding: got %0d, expected 0", outstanding); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b, expected 0", m_valid); end
        if (s_accept !== 3'b000) begin errors++; $display("FAIL rst_mid_accept: got %b, expected 000", s_accept); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || s_accept !== 3'b000) begin
                errors++;
                $display("FAIL rst_release_quiet: valid=%b accept=%b, expected 0 and 000", m_valid, s_accept);
            end
        end
        step();
        s_valid = 3'b000;
    endtask

`ifdef PZCOREBUS_ORDERED_RESPONSE_MUX_OUTPUT_SLICE_EN
    task automatic test_slice();
        push(2'd0); push(2'd1); push(2'd0); push(2'd1);
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    drive_beat(b % 2, 16'h6000 + 16'(b), 1'b1);
                end
            end
            begin
                @(negedge clk);
                checks++;
                if (m_valid !== 1'b0) begin errors++; $display("FAIL slice_latency: got valid=%b, expected 0", m_valid); end
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    checks++;
                    if (m_valid !== 1'b1) begin errors++; $display("FAIL slice_throughput: cycle %0d valid=%b, expected 1", i, m_valid); end
                end
            end
        join
        wait_drain();
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        hold_q    = 1'b0;
        held_data = 16'h0000;
        pkt_done  = 1'b0;
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel       = 2'd0;
        s_valid   = 3'b111;
        s_data    = {3{16'hDEAD}};
        s_last    = 3'b111;
        m_accept  = 1'b1;
        test_reset();
        test_order();
        test_full();
        test_error();
        test_backpressure();
        test_reset_mid();
`ifdef PZCOREBUS_ORDERED_RESPONSE_MUX_OUTPUT_SLICE_EN
        test_slice();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
